// File: rtl/burst_playback.sv
// burst_playback: reads packed waveform words back from a pipelined SRAM and
// streams them to the DAC. Each 32-bit word holds two samples, so one read
// address every second cycle keeps the DAC fed without gaps. Supports a burst
// length, a pass count (0 = loop until trigger release) and abort on release.
module burst_playback #(
  parameter int DAC_W  = 14,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2
) (
  input  logic              HS_CLK,
  input  logic              RST_N,
  input  logic              TRIG,
  input  logic [ADDR_W-1:0] BURST_LEN,
  input  logic [7:0]        LOOPS,
  input  logic [31:0]       SRAM_DATA,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_ADSC_N,
  output logic              SRAM_OE_N,
  output logic [DAC_W-1:0]  DAC_DATA,
  output logic              DAC_VALID,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN, FINISH} state_t;

  localparam logic [DAC_W-1:0]  MIDSCALE  = DAC_W'(1) << (DAC_W - 1);
  // Read-pipeline pattern when only the oldest outstanding word remains.
  localparam logic [RD_LAT-1:0] PIPE_LAST = RD_LAT'(1) << (RD_LAT - 1);

  state_t            state;
  logic              trig_meta;
  logic              trig_sync;
  logic              trig_prev;
  logic              trig_rise;
  logic              trig_fall;
  logic              abort;
  logic [ADDR_W-1:0] last_k;      // len - 1, latched at start
  logic [7:0]        loops_left;
  logic              addr_phase;  // high during an address-issue cycle
  logic [RD_LAT-1:0] vld_pipe;    // bit i set: a word issued i+1 cycles ago
  logic              hi_pending;
  logic [DAC_W-1:0]  hi_word;
  logic              sram_data_unused;

  // Padding bits above DAC_W in each half are don't-care.
  assign sram_data_unused = ^SRAM_DATA;

  assign trig_rise = trig_sync & ~trig_prev;
  assign trig_fall = ~trig_sync & trig_prev;
  assign abort     = trig_fall && (state == PLAY || state == DRAIN);

  // Two-flop synchronizer for the asynchronous trigger, plus edge history.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as the hardware does.
  always_ff @(posedge HS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      trig_meta <= 1'b0;
      trig_sync <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      trig_meta <= TRIG;
      trig_sync <= trig_meta;
      trig_prev <= trig_sync;
    end
  end

  // Playback FSM, SRAM address generator and DAC data path.
  // NOTE: the read pipeline and sample holding registers are reset too, so an
  // abort or reset never lets a stale in-flight word reach the DAC.
  always_ff @(posedge HS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      last_k      <= '0;
      loops_left  <= '0;
      addr_phase  <= 1'b0;
      vld_pipe    <= '0;
      hi_pending  <= 1'b0;
      hi_word     <= '0;
      SRAM_ADDR   <= '0;
      SRAM_ADSC_N <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      DAC_DATA    <= MIDSCALE;
      DAC_VALID   <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else if (abort) begin
      // Trigger released: drop everything in flight, no DONE.
      state       <= IDLE;
      addr_phase  <= 1'b0;
      vld_pipe    <= '0;
      hi_pending  <= 1'b0;
      SRAM_ADSC_N <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      DAC_DATA    <= MIDSCALE;
      DAC_VALID   <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      vld_pipe <= RD_LAT'({vld_pipe, ~SRAM_ADSC_N});

      // Capture a returning word: low sample now, high sample next cycle.
      if (vld_pipe[RD_LAT-1]) begin
        DAC_DATA   <= SRAM_DATA[DAC_W-1:0];
        hi_word    <= SRAM_DATA[16 +: DAC_W];
        hi_pending <= 1'b1;
        DAC_VALID  <= 1'b1;
      end else if (hi_pending) begin
        DAC_DATA   <= hi_word;
        hi_pending <= 1'b0;
        DAC_VALID  <= 1'b1;
      end else begin
        DAC_DATA   <= MIDSCALE;
        DAC_VALID  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (trig_rise) begin
            last_k     <= BURST_LEN - ADDR_W'(1);
            loops_left <= LOOPS;
            BUSY       <= 1'b1;
            if (BURST_LEN == '0) begin
              state <= FINISH;
              DONE  <= 1'b1;
            end else begin
              state       <= PLAY;
              SRAM_ADDR   <= '0;
              SRAM_ADSC_N <= 1'b0;
              SRAM_OE_N   <= 1'b0;
              addr_phase  <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (addr_phase) begin
            SRAM_ADSC_N <= 1'b1;
            addr_phase  <= 1'b0;
          end else if (SRAM_ADDR == last_k && loops_left == 8'd1) begin
            state <= DRAIN;
            if (vld_pipe == PIPE_LAST) SRAM_OE_N <= 1'b1;
          end else begin
            SRAM_ADSC_N <= 1'b0;
            addr_phase  <= 1'b1;
            if (SRAM_ADDR == last_k) begin
              SRAM_ADDR <= '0;
              if (loops_left != 8'd0) loops_left <= loops_left - 8'd1;
            end else begin
              SRAM_ADDR <= SRAM_ADDR + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (vld_pipe == PIPE_LAST) SRAM_OE_N <= 1'b1;
          // Last high sample is on the DAC now and nothing is in flight.
          if (DAC_VALID && !hi_pending && vld_pipe == '0) begin
            state <= FINISH;
            DONE  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_playback.sv
// Testbench for burst_playback: three instances (RD_LAT 1, 2, 4), each with a
// pipelined SRAM model. Expected addresses and samples are queued with the
// cycle they must appear in, then popped and compared cycle by cycle.
module tb_burst_playback;

  localparam int             A0  = 3;         // first address cycle after TRIG drive
  localparam logic [13:0]    MID = 14'h2000;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic                  hs_clk;
  logic                  rst_n;
  logic [2:0]            trig;
  logic [16:0]           burst_len;
  logic [7:0]            loops;
  logic [2:0][16:0]      sram_addr;
  logic [2:0]            sram_adsc_n;
  logic [2:0]            sram_oe_n;
  logic [2:0][13:0]      dac_data;
  logic [2:0]            dac_valid;
  logic [2:0]            busy;
  logic [2:0]            done;

  int   n_cmp = 0;
  int   n_err = 0;
  int   sel;
  int   cyc;
  int   stop_cyc;
  int   done_cyc;
  int   oe_first;
  int   oe_last;
  ev_t  addr_q[$];
  ev_t  samp_q[$];

  function automatic logic [31:0] word_of(input logic [16:0] k);
    logic [15:0] lo;
    lo = 16'({k, 1'b0});
    return {lo | 16'd1, lo};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [3:0]       rd_v;
    logic [3:0][16:0] rd_a;
    logic [31:0]      rd_data;

    // Pipelined SRAM: word addressed in cycle T is on the bus in cycle T+LAT.
    always @(posedge hs_clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_v <= '0;
        rd_a <= '0;
      end else begin
        rd_v <= {rd_v[2:0], ~sram_adsc_n[g]};
        rd_a <= {rd_a[2:0], sram_addr[g]};
      end
    end
    assign rd_data = (rd_v[LAT-1] && !sram_oe_n[g]) ? word_of(rd_a[LAT-1]) : 32'hDEAD_BEEF;

    burst_playback #(.DAC_W(14), .ADDR_W(17), .RD_LAT(LAT)) u_dut (
      .HS_CLK      (hs_clk),
      .RST_N       (rst_n),
      .TRIG        (trig[g]),
      .BURST_LEN   (burst_len),
      .LOOPS       (loops),
      .SRAM_DATA   (rd_data),
      .SRAM_ADDR   (sram_addr[g]),
      .SRAM_ADSC_N (sram_adsc_n[g]),
      .SRAM_OE_N   (sram_oe_n[g]),
      .DAC_DATA    (dac_data[g]),
      .DAC_VALID   (dac_valid[g]),
      .BUSY        (busy[g]),
      .DONE        (done[g])
    );
  end

  initial hs_clk = 1'b0;
  always #5 hs_clk = ~hs_clk;

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 2 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (inst %0d, cyc %0d): observed %0h expected %0h", tag, sel, cyc, obs, exp);
    end
  endtask

  task automatic check_reset(input int s);
    sel = s;
    check("rst_addr",   32'(sram_addr[s]),   32'd0);
    check("rst_adsc_n", 32'(sram_adsc_n[s]), 32'd1);
    check("rst_oe_n",   32'(sram_oe_n[s]),   32'd1);
    check("rst_dac",    32'(dac_data[s]),    32'(MID));
    check("rst_valid",  32'(dac_valid[s]),   32'd0);
    check("rst_busy",   32'(busy[s]),        32'd0);
    check("rst_done",   32'(done[s]),        32'd0);
  endtask

  // Queue the expected address/sample stream for one burst.
  task automatic expect_burst(input int len, input int passes, input int lat);
    int n;
    n = 0;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < len; k++) begin
        logic [16:0] kk;
        logic [31:0] w;
        kk = 17'(k);
        w  = word_of(kk);
        addr_q.push_back('{A0 + 2 * n, 32'(kk)});
        samp_q.push_back('{A0 + 2 * n + lat + 1, {18'd0, w[13:0]}});
        samp_q.push_back('{A0 + 2 * n + lat + 2, {18'd0, w[29:16]}});
        n++;
      end
    end
    if (n == 0) begin
      done_cyc = A0;
      oe_first = 1;
      oe_last  = 0;
    end else begin
      done_cyc = A0 + 2 * n + lat + 1;
      oe_first = A0;
      oe_last  = A0 + 2 * n - 2 + lat;
    end
  endtask

  task automatic start_burst(input int s, input int len, input int lps, input int passes);
    sel       = s;
    burst_len = 17'(len);
    loops     = 8'(lps);
    addr_q.delete();
    samp_q.delete();
    expect_burst(len, passes, lat_of(s));
    cyc       = 0;
    stop_cyc  = 1 << 30;
    trig[s]   = 1'b1;
  endtask

  // Compare every output of the selected instance for n cycles.
  task automatic watch(input int n);
    ev_t         e;
    logic        exp_adsc;
    logic        exp_valid;
    logic [13:0] exp_dac;
    bit          act;
    repeat (n) begin
      @(negedge hs_clk);
      cyc++;
      act       = cyc < stop_cyc;
      exp_adsc  = 1'b1;
      exp_valid = 1'b0;
      exp_dac   = MID;
      if (act && addr_q.size() != 0 && addr_q[0].cyc == cyc) begin
        e = addr_q.pop_front();
        exp_adsc = 1'b0;
        check("addr", 32'(sram_addr[sel]), e.val);
      end
      if (act && samp_q.size() != 0 && samp_q[0].cyc == cyc) begin
        e = samp_q.pop_front();
        exp_valid = 1'b1;
        exp_dac   = e.val[13:0];
      end
      check("adsc_n",    32'(sram_adsc_n[sel]), 32'(exp_adsc));
      check("dac_valid", 32'(dac_valid[sel]),   32'(exp_valid));
      check("dac_data",  32'(dac_data[sel]),    32'(exp_dac));
      check("oe_n",      32'(sram_oe_n[sel]),   32'(!(act && cyc >= oe_first && cyc <= oe_last)));
      check("busy",      32'(busy[sel]),        32'(act && cyc >= A0 && cyc <= done_cyc));
      check("done",      32'(done[sel]),        32'(act && cyc == done_cyc));
    end
  endtask

  task automatic end_scn();
    trig[sel] = 1'b0;
    repeat (4) @(negedge hs_clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    trig      = '0;
    burst_len = '0;
    loops     = '0;
    sel       = 0;
    cyc       = 0;
    repeat (3) @(negedge hs_clk);
    for (int s = 0; s < 3; s++) check_reset(s);
    rst_n = 1'b1;
    repeat (3) @(negedge hs_clk);

    // Single pass, RD_LAT=2; extra cycles with TRIG held high must not retrigger.
    start_burst(1, 4, 1, 1);
    watch(done_cyc + 6);
    end_scn();

    // Three passes of three words, seamless wrap.
    start_burst(1, 3, 3, 3);
    watch(done_cyc + 4);
    end_scn();

    // Endless looping, aborted by TRIG release after 40 cycles.
    start_burst(1, 5, 0, 10);
    watch(40);
    trig[1]  = 1'b0;
    stop_cyc = 43;
    watch(10);
    end_scn();

    // Zero-length burst: DONE one cycle after start, no SRAM access.
    start_burst(1, 0, 1, 1);
    watch(8);
    end_scn();

    // Sub-cycle TRIG glitch mid-burst is never seen; all 16 samples out.
    start_burst(1, 8, 1, 1);
    watch(10);
    trig[1] = 1'b0;
    #2;
    trig[1] = 1'b1;
    watch(done_cyc - 10 + 4);
    end_scn();

    // Reset while word 2 is being addressed, then a clean restart.
    start_burst(1, 8, 1, 1);
    watch(A0 + 4);
    rst_n = 1'b0;
    #1;
    check_reset(1);
    trig[1] = 1'b0;
    repeat (2) @(negedge hs_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge hs_clk);
    start_burst(1, 4, 1, 1);
    watch(done_cyc + 4);
    end_scn();

    // Latency sweep: RD_LAT=1 and RD_LAT=4.
    start_burst(0, 4, 1, 1);
    watch(done_cyc + 4);
    end_scn();
    start_burst(2, 4, 1, 1);
    watch(done_cyc + 4);
    end_scn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
